// File: rtl/power_seq_if.sv
// Signal bundle between the power button FSM side and the rail sequencer.
// The sequencer takes the slave view; the button/regulator side takes the master view.
interface power_seq_if #(
  parameter int NUM_RAILS = 3
);
  logic                 ce;
  logic                 pwr_enable;
  logic [NUM_RAILS-1:0] pgood;
  logic [NUM_RAILS-1:0] rail_en;
  logic                 soc_rst_n;
  logic                 pwr_fault;
  logic                 busy;

  modport master (
    output ce, pwr_enable, pgood,
    input  rail_en, soc_rst_n, pwr_fault, busy
  );

  modport slave (
    input  ce, pwr_enable, pgood,
    output rail_en, soc_rst_n, pwr_fault, busy
  );
endinterface

// File: rtl/power_seq.sv
// Rail sequencer: ascending ramp gated on per-rail power-good with timeout,
// timed SoC reset release, descending power-down and a sticky fault latch.
module power_seq #(
  parameter int         NUM_RAILS   = 3,
  parameter logic [7:0] PG_TIMEOUT  = 8'd100,
  parameter logic [7:0] RESET_DELAY = 8'd10,
  parameter logic [7:0] OFF_DELAY   = 8'd5
) (
  input logic        clk,
  input logic        rst,
  power_seq_if.slave bus
);
  localparam int               IDX_W    = $clog2(NUM_RAILS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

  typedef enum logic [2:0] {
    S_OFF,
    S_UP,
    S_RST_HOLD,
    S_ON,
    S_DOWN,
    S_FAULT
  } state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [7:0]           cnt_reg, cnt_next;
  logic [NUM_RAILS-1:0] rail_en_reg, rail_en_next;
  logic                 soc_rst_n_reg, soc_rst_n_next;
  logic                 pwr_fault_reg, pwr_fault_next;
  logic                 busy_reg, busy_next;

  logic [NUM_RAILS-1:0] idx_onehot;
  logic [NUM_RAILS-1:0] up_onehot;
  logic                 pg_cur;
  logic                 pg_all;

  // One-hot decode of idx avoids an out-of-range select when NUM_RAILS is not a power of two.
  for (genvar gi = 0; gi < NUM_RAILS; gi++) begin : g_idx_dec
    assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
  end

  assign up_onehot = {idx_onehot[NUM_RAILS-2:0], 1'b0};
  assign pg_cur    = |(bus.pgood & idx_onehot);
  assign pg_all    = &bus.pgood;

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    rail_en_next   = rail_en_reg;
    soc_rst_n_next = soc_rst_n_reg;
    pwr_fault_next = pwr_fault_reg;

    unique case (state_reg)
      S_OFF: begin
        if (bus.pwr_enable) begin
          state_next     = S_UP;
          idx_next       = '0;
          cnt_next       = '0;
          rail_en_next   = NUM_RAILS'(1);
          pwr_fault_next = 1'b0;
        end
      end

      S_UP: begin
        if (!bus.pwr_enable) begin
          state_next = S_DOWN;
          cnt_next   = '0;
        end else if (pg_cur && (idx_reg == LAST_IDX)) begin
          state_next = S_RST_HOLD;
          cnt_next   = '0;
        end else if (pg_cur) begin
          idx_next     = idx_reg + IDX_W'(1);
          cnt_next     = '0;
          rail_en_next = rail_en_reg | up_onehot;
        end else if (cnt_reg == PG_TIMEOUT - 8'd1) begin
          state_next     = S_FAULT;
          cnt_next       = '0;
          rail_en_next   = '0;
          soc_rst_n_next = 1'b0;
          pwr_fault_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_RST_HOLD: begin
        if (!bus.pwr_enable) begin
          state_next = S_DOWN;
          idx_next   = LAST_IDX;
          cnt_next   = '0;
        end else if (!pg_all) begin
          state_next     = S_FAULT;
          cnt_next       = '0;
          rail_en_next   = '0;
          soc_rst_n_next = 1'b0;
          pwr_fault_next = 1'b1;
        end else if (cnt_reg == RESET_DELAY - 8'd1) begin
          state_next     = S_ON;
          cnt_next       = '0;
          soc_rst_n_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_ON: begin
        // A lost rail wins over a simultaneous power-down request.
        if (!pg_all) begin
          state_next     = S_FAULT;
          cnt_next       = '0;
          rail_en_next   = '0;
          soc_rst_n_next = 1'b0;
          pwr_fault_next = 1'b1;
        end else if (!bus.pwr_enable) begin
          state_next     = S_DOWN;
          idx_next       = LAST_IDX;
          cnt_next       = '0;
          soc_rst_n_next = 1'b0;
        end
      end

      S_DOWN: begin
        if (cnt_reg == OFF_DELAY - 8'd1) begin
          rail_en_next = rail_en_reg & ~idx_onehot;
          cnt_next     = '0;
          if (idx_reg == '0) begin
            state_next = S_OFF;
          end else begin
            idx_next = idx_reg - IDX_W'(1);
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_FAULT: begin
        if (!bus.pwr_enable) begin
          state_next = S_OFF;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next     = S_OFF;
        idx_next       = '0;
        cnt_next       = '0;
        rail_en_next   = '0;
        soc_rst_n_next = 1'b0;
      end
    endcase

    busy_next = (state_next == S_UP) || (state_next == S_RST_HOLD) || (state_next == S_DOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_OFF;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      rail_en_reg   <= '0;
      soc_rst_n_reg <= 1'b0;
      pwr_fault_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else if (bus.ce) begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cnt_reg       <= cnt_next;
      rail_en_reg   <= rail_en_next;
      soc_rst_n_reg <= soc_rst_n_next;
      pwr_fault_reg <= pwr_fault_next;
      busy_reg      <= busy_next;
    end
  end

  assign bus.rail_en   = rail_en_reg;
  assign bus.soc_rst_n = soc_rst_n_reg;
  assign bus.pwr_fault = pwr_fault_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: doc/power_seq.md
# power_seq

Rail sequencer directly downstream of the power button state machine. It consumes that block's `pwr_enable` level and turns it into ordered rail enables: ramp-up in ascending rail order, each rail gated on its power-good with a timeout, then timed SoC reset release. Power-down runs in reverse order. A fault latch reports timeouts and power-good loss to the status registers. It runs on the slow clock enable shared with the button FSM.

## Interface

- `NUM_RAILS`, 3: number of sequenced rails (2..8); rail 0 comes up first.
- `PG_TIMEOUT`, 8'd100: `ce` ticks allowed for a rail's `pgood` after its enable (1..255).
- `RESET_DELAY`, 8'd10: `ce` ticks from last `pgood` to `soc_rst_n` release (1..255).
- `OFF_DELAY`, 8'd5: `ce` ticks between successive rail disables on power-down (1..255).

Ports:

- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: slow clock enable, one `clk` cycle wide.
- `pwr_enable` in 1: power request from the button FSM.
- `pgood` in NUM_RAILS: per-rail power-good, already synchronised.
- `rail_en` out NUM_RAILS: per-rail regulator enables.
- `soc_rst_n` out 1: SoC reset, active-low.
- `pwr_fault` out 1: sticky fault flag.
- `busy` out 1: high in UP, RST_HOLD, DOWN.

## Operation

- Reset values: `rail_en`=0, `soc_rst_n`=0, `pwr_fault`=0, `busy`=0; state OFF; `idx`=0; `cnt`=0.
- State, `idx` and `cnt` update only on `clk` edges with `ce`=1. `rst` acts regardless of `ce`. All outputs are registered.
- `cnt` is 8-bit and is zeroed on every state or `idx` change.
- **OFF**:
  - If `pwr_enable`=1: go to UP, set `idx`=0, set `rail_en[0]`, clear `pwr_fault`.
- **UP** (`rail_en[idx:0]` set), priority high to low:
  1. `pwr_enable`=0: go to DOWN, keep `idx`.
  2. `pgood[idx]`=1 and `idx`=NUM_RAILS-1: go to RST_HOLD.
  3. `pgood[idx]`=1 otherwise: increment `idx`, set `rail_en[idx+1]`.
  4. `cnt`=PG_TIMEOUT-1: go to FAULT.
  5. Otherwise increment `cnt`.
- **RST_HOLD**:
  - `pwr_enable`=0: go to DOWN with `idx`=NUM_RAILS-1.
  - Any `pgood` low: go to FAULT.
  - `cnt`=RESET_DELAY-1: go to ON, drive `soc_rst_n`=1.
- **ON**:
  - Any `pgood` low: go to FAULT. This takes priority over `pwr_enable`=0 on the same tick.
  - Otherwise `pwr_enable`=0: go to DOWN, `idx`=NUM_RAILS-1, drive `soc_rst_n`=0 on the same edge.
- **DOWN** (`soc_rst_n`=0):
  - On `cnt`=OFF_DELAY-1: clear `rail_en[idx]`. If `idx`=0 go to OFF, else decrement `idx`.
  - `pwr_enable` and `pgood` are ignored until OFF is reached. A re-request is acted on from OFF on the next tick.
- **FAULT**:
  - On entry, on the same edge: `rail_en`=0, `soc_rst_n`=0, `pwr_fault`=1.
  - Exit to OFF only on a tick with `pwr_enable`=0. `pwr_fault` stays set through OFF until the next OFF→UP.
- `rail_en` bits above `idx` are never set. Rails come up strictly ascending and go down strictly descending.

## Timing

- OFF→UP: `rail_en[0]` rises on the first `ce` edge that samples `pwr_enable`=1.
- Per-rail step: a `pgood[i]` sampled high at tick T causes `rail_en[i+1]` to rise at the edge of T.
- Worst-case ramp before a fault: PG_TIMEOUT ticks per rail.
  - `pgood` never rising causes FAULT on the PG_TIMEOUT-th tick after the enable.
- `soc_rst_n` rises exactly RESET_DELAY ticks after the tick that sampled the last `pgood`.
- Power-down: the first rail drops OFF_DELAY ticks after DOWN entry, then one rail every OFF_DELAY ticks.
  - Full-on to OFF takes NUM_RAILS×OFF_DELAY ticks.
- Reset mid-operation: all outputs return to reset values on the next `clk` edge.
- `ce` held low freezes state and outputs.

## Test plan

All scenarios use NUM_RAILS=3, PG_TIMEOUT=5, RESET_DELAY=2, OFF_DELAY=1, with `ce` every 4th `clk`.

- Nominal up: raise `pwr_enable`, each `pgood[i]` tied to `rail_en[i]` delayed one tick.
  - `rail_en` goes 001→011→111.
  - `soc_rst_n`=1 two ticks after `pgood[2]`; `busy` drops.
- Nominal down from ON: drop `pwr_enable`.
  - `soc_rst_n`=0 on the same edge.
  - `rail_en` goes 111→011→001→000 at one-tick spacing, then OFF.
- Timeout: hold `pgood[1]`=0.
  - On the 5th tick after `rail_en[1]` rises: `rail_en`=000, `pwr_fault`=1.
  - `pwr_fault` is held while `pwr_enable`=1.
  - Drop then re-raise `pwr_enable`: `pwr_fault` clears as `rail_en[0]` rises.
- Abort mid-ramp: drop `pwr_enable` while `idx`=1.
  - `rail_en` goes 011→001→000, one tick apart; `pwr_fault` stays 0.
  - Re-raising `pwr_enable` during DOWN has no effect until OFF.
- Simultaneous events in ON: drop `pgood[0]` and `pwr_enable` on the same tick.
  - Next `ce` edge enters FAULT: `rail_en`=000, `pwr_fault`=1.
- Reset mid-ramp and `ce` gating:
  - Assert `rst` for one `clk` at `rail_en`=011: all outputs return to 0 on the next edge.
  - Holding `ce`=0 for 20 `clk` cycles leaves outputs unchanged.
